// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
//  Module      : acc_bank
//  Description : Bank of NUM_ACC accumulators of WIDTH bits. A small op set
//                (load/add/sub/shl/shr/clear) is applied directly in the
//                register stage. The block keeps shared registered Z/C/N
//                flags. It also has a save/restore stack of STACK_DEPTH
//                entries, each holding {data, zf, cf, nf}.
//
//  Optional    : ACC_SAT_EN. When defined, add saturates to all-ones on
//                carry and sub saturates to zero on borrow. In that mode cf
//                flags that saturation occurred.
//
//  Ports       : clk        system clock, rising edge
//                rst        synchronous reset, active low
//                sel        accumulator select (>= NUM_ACC: hold, acc reads 0)
//                op         operation code
//                X          operand / load data
//                push/pop   stack save / restore of the selected accumulator
//                acc        combinational read of selected accumulator
//                zf/cf/nf   registered flags
//                stk_full   stack holds STACK_DEPTH entries
//                stk_empty  stack holds no entries
//                stk_err    sticky stack misuse indication
//
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_bank #(
    parameter int WIDTH       = 8,
    parameter int NUM_ACC     = 2,
    parameter int STACK_DEPTH = 4,
    localparam int SEL_W      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] acc,
    output logic             zf,
    output logic             cf,
    output logic             nf,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam int c_PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int c_ENT_W = WIDTH + 3;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_DEPTH   = c_PTR_W'(STACK_DEPTH);
    localparam logic [SEL_W:0]     c_NUM_ACC = (SEL_W + 1)'(NUM_ACC);

    localparam logic [2:0] c_OP_LOAD  = 3'b001;
    localparam logic [2:0] c_OP_ADD   = 3'b010;
    localparam logic [2:0] c_OP_SUB   = 3'b011;
    localparam logic [2:0] c_OP_SHL   = 3'b100;
    localparam logic [2:0] c_OP_SHR   = 3'b101;
    localparam logic [2:0] c_OP_CLEAR = 3'b110;

    logic [WIDTH-1:0]   r_acc [NUM_ACC];
    logic [c_ENT_W-1:0] r_stk [STACK_DEPTH];
    logic [c_PTR_W-1:0] r_sp;
    logic               r_zf;
    logic               r_cf;
    logic               r_nf;
    logic               r_err;

    logic               w_sel_ok;
    logic [WIDTH-1:0]   w_acc_sel;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_cf_new;
    logic               w_op_wr;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_op_en;
    logic               w_err;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_ENT_W-1:0] w_top;

    // Compare one bit wider so that NUM_ACC == 2**SEL_W does not truncate.
    assign w_sel_ok  = ({1'b0, sel} < c_NUM_ACC);
    assign w_acc_sel = w_sel_ok ? r_acc[sel] : '0;

    // The extra top bit is the carry for add and the unsigned borrow for sub.
    assign w_sum  = {1'b0, w_acc_sel} + {1'b0, X};
    assign w_diff = {1'b0, w_acc_sel} - {1'b0, X};

    always_comb begin
        w_res    = w_acc_sel;
        w_cf_new = r_cf;
        w_op_wr  = 1'b0;
        case (op)
            c_OP_LOAD: begin
                w_res    = X;
                w_cf_new = 1'b0;
                w_op_wr  = 1'b1;
            end
            c_OP_ADD: begin
`ifdef ACC_SAT_EN
                w_res    = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
                w_res    = w_sum[WIDTH-1:0];
`endif
                w_cf_new = w_sum[WIDTH];
                w_op_wr  = 1'b1;
            end
            c_OP_SUB: begin
`ifdef ACC_SAT_EN
                w_res    = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
                w_res    = w_diff[WIDTH-1:0];
`endif
                w_cf_new = w_diff[WIDTH];
                w_op_wr  = 1'b1;
            end
            c_OP_SHL: begin
                w_res    = w_acc_sel << 1;
                w_cf_new = w_acc_sel[WIDTH-1];
                w_op_wr  = 1'b1;
            end
            c_OP_SHR: begin
                w_res    = w_acc_sel >> 1;
                w_cf_new = w_acc_sel[0];
                w_op_wr  = 1'b1;
            end
            c_OP_CLEAR: begin
                w_res    = '0;
                w_cf_new = 1'b0;
                w_op_wr  = 1'b1;
            end
            default: begin
                // hold and reserved code leave everything untouched
            end
        endcase
    end

    assign w_full  = (r_sp == c_DEPTH);
    assign w_empty = (r_sp == '0);

    // Stack activity and errors only apply to a valid accumulator select.
    // A lone pop request (legal or not) suppresses the op for that cycle.
    assign w_push_ok = w_sel_ok & push & ~pop & ~w_full;
    assign w_pop_ok  = w_sel_ok & pop & ~push & ~w_empty;
    assign w_op_en   = w_sel_ok & w_op_wr & ~(pop & ~push);
    assign w_err     = w_sel_ok & ((push & pop)
                                 | (push & ~pop & w_full)
                                 | (pop & ~push & w_empty));

    assign w_wr_idx = c_IDX_W'(r_sp);
    assign w_rd_idx = c_IDX_W'(r_sp - c_PTR_ONE);
    assign w_top    = r_stk[w_rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= '0;
            end
            r_zf  <= 1'b0;
            r_cf  <= 1'b0;
            r_nf  <= 1'b0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_err) begin
                r_err <= 1'b1;
            end
            if (w_pop_ok) begin
                r_acc[sel] <= w_top[c_ENT_W-1:3];
                r_zf       <= w_top[2];
                r_cf       <= w_top[1];
                r_nf       <= w_top[0];
                r_sp       <= r_sp - c_PTR_ONE;
            end else begin
                if (w_push_ok) begin
                    r_sp <= r_sp + c_PTR_ONE;
                end
                if (w_op_en) begin
                    r_acc[sel] <= w_res;
                    r_zf       <= (w_res == '0);
                    r_cf       <= w_cf_new;
                    r_nf       <= w_res[WIDTH-1];
                end
            end
        end
    end

    // Stack storage needs no reset: entries are only read below the pointer.
    // A push captures the pre-edge accumulator and flags.
    always_ff @(posedge clk) begin
        if (rst && w_push_ok) begin
            r_stk[w_wr_idx] <= {w_acc_sel, r_zf, r_cf, r_nf};
        end
    end

    assign acc       = w_acc_sel;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign nf        = r_nf;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign stk_err   = r_err;

endmodule
`default_nettype wire

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Parametrised successor to the single 8-bit accumulator register of the CPU datapath.
- Holds NUM_ACC accumulators of WIDTH bits and applies a small op set (load/add/sub/shift/clear) directly in the register stage.
- Produces registered Z/C/N flags and provides a save/restore stack of STACK_DEPTH entries for subroutine/interrupt context.
- Sits between the ALU operand bus (X) and the control unit.

Parameters:
- WIDTH, 8, data width of each accumulator and of X.
- NUM_ACC, 2, number of accumulators; >=1; SEL_W = max(1, clog2(NUM_ACC)).
- STACK_DEPTH, 4, number of save/restore entries; >=1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset on next rising clk edge).
- sel  input  SEL_W  accumulator selected for op/push/pop and for the acc output; values >= NUM_ACC behave as hold, and acc reads 0.
- op  input  3  operation code (see Behaviour).
- X  input  WIDTH  operand / load data.
- push  input  1  save selected accumulator plus flags onto the stack.
- pop  input  1  restore top-of-stack into selected accumulator plus flags.
- acc  output  WIDTH  combinational read of the selected accumulator's current registered value.
- zf  output  1  zero flag (registered).
- cf  output  1  carry/borrow/shift-out flag (registered).
- nf  output  1  negative flag = result MSB (registered).
- stk_full  output  1  stack holds STACK_DEPTH entries.
- stk_empty  output  1  stack holds 0 entries.
- stk_err  output  1  sticky error: push-when-full, pop-when-empty, or push+pop in the same cycle.

Behaviour:
- Reset (rst=0 at clk edge):
  - All accumulators, zf, cf, nf, stack pointer and stk_err go to 0.
  - stk_empty=1, stk_full=0.
  - Reset overrides any op/push/pop in the same cycle, including mid-sequence.
- Op codes, applied to acc[sel] at the clk edge (single-cycle latency: the new value is visible on acc the cycle after the edge):
  - 000 hold: no change; flags unchanged.
  - 001 load: R = X; cf = 0.
  - 010 add: R = acc + X, modulo 2^WIDTH; cf = carry out.
  - 011 sub: R = acc - X, modulo 2^WIDTH; cf = 1 if acc < X (borrow, unsigned).
  - 100 shl: R = acc << 1, LSB filled with 0; cf = old MSB.
  - 101 shr: logical shift right, MSB filled with 0; cf = old LSB.
  - 110 clear: R = 0; cf = 0.
  - 111 reserved: treated as hold.
- Flags:
  - Every non-hold op writes all three flags from R: zf = (R == 0), nf = R[WIDTH-1].
  - Flags are shared, not per accumulator.
- Stack:
  - Each entry is {WIDTH data, zf, cf, nf}. The pointer counts 0..STACK_DEPTH.
  - push (pop=0, not full): stores the pre-edge acc[sel] and pre-edge flags; pointer +1. An op in the same cycle still executes normally.
  - pop (push=0, not empty): acc[sel] and flags load from the top entry; pointer -1. Op is ignored that cycle.
  - push when full, or pop when empty: no stack, accumulator or flag change. Op still executes if pop=0. Sets stk_err.
  - push=1 and pop=1 together: both ignored; op executes; sets stk_err.
  - stk_err stays 1 until reset.
  - stk_full and stk_empty are decoded from the registered pointer.
- No combinational path from X/op to zf/cf/nf; acc depends combinationally only on sel and registers.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - add saturates to all-ones on carry.
  - sub saturates to 0 on borrow.
  - cf is set exactly when saturation occurred; zf and nf are taken from the saturated R.
  - Shifts, load and clear are unchanged.
- Undefined: wrap-around arithmetic as specified above.

Test Plan:
- Use WIDTH=8, NUM_ACC=2, STACK_DEPTH=4.
- Reset then load: rst=0 one edge, then sel=0 op=001 X=8'h5A.
  - After reset edge: acc=0, zf=0, stk_empty=1.
  - After load edge: acc=8'h5A, zf=0, cf=0, nf=0.
- Add carry and sub borrow, sel=1: load 8'hF0, add X=8'h20.
  - Without macro: acc=8'h10, cf=1. With ACC_SAT_EN: acc=8'hFF, cf=1.
  - Then clear, sub X=8'h01. Without macro: acc=8'hFF, cf=1, nf=1. With ACC_SAT_EN: acc=0, zf=1, cf=1.
- Shifts: load 8'h81, shl -> acc=8'h02, cf=1; shr -> acc=8'h01, cf=0; shr -> acc=0, zf=1, cf=1.
- Push/pop round trip:
  - acc0=8'h33, then push with op=001 X=8'h44 in the same cycle -> acc0=8'h44.
  - pop -> acc0=8'h33, flags restored, stk_empty=1.
- Overflow and underflow:
  - 4 pushes -> stk_full=1. 5th push -> stk_err=1, pointer stays 4.
  - 4 pops then 1 extra pop -> stk_empty=1, acc unchanged.
  - stk_err stays 1 until rst=0.
- Simultaneous/reset edge cases:
  - push=pop=1 with op=010 X=1 on acc=8'h07 -> acc=8'h08, stack unchanged, stk_err=1.
  - rst=0 together with pop -> everything 0.
